// File: rtl/bulk_in_pkg.sv
// Shared types and helpers for the bulk IN scheduler: FSM states,
// response codes and a constant-foldable ceil(log2).
package bulk_in_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_XFER    = 2'd1,
    ST_WAIT_HS = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    RESP_NONE  = 3'd0,
    RESP_DATA  = 3'd1,
    RESP_NAK   = 3'd2,
    RESP_STALL = 3'd3,
    RESP_ZLP   = 3'd4
  } resp_t;

  // ceil(log2(v)); returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bulk_in_mux.sv
// N:1 AXI-stream select of the endpoint byte streams onto the shared IN path,
// with ready steered back only to the selected endpoint.
module bulk_in_mux
  import bulk_in_pkg::*;
#(
  parameter int unsigned NUM_EP = 2,
  parameter int unsigned SEL_W  = 1
) (
  input  logic                  en,
  input  logic [SEL_W-1:0]      sel,
  input  logic [NUM_EP-1:0]     ep_tvalid_i,
  input  logic [NUM_EP-1:0]     ep_tlast_i,
  input  logic [8*NUM_EP-1:0]   ep_tdata_i,
  output logic [NUM_EP-1:0]     ep_tready_o,
  input  logic                  m_tready_i,
  output logic                  m_tvalid_o,
  output logic [7:0]            m_tdata_o,
  output logic                  src_tlast_o
);

  always_comb begin
    ep_tready_o = '0;
    m_tvalid_o  = 1'b0;
    m_tdata_o   = '0;
    src_tlast_o = 1'b0;
    if (en) begin
      for (int unsigned k = 0; k < NUM_EP; k++) begin
        if (sel == SEL_W'(k)) begin
          m_tvalid_o     = ep_tvalid_i[k];
          m_tdata_o      = ep_tdata_i[8*k +: 8];
          src_tlast_o    = ep_tlast_i[k];
          ep_tready_o[k] = m_tready_i;
        end
      end
    end
  end

endmodule

// File: rtl/bulk_in_sched.sv
// Bulk IN scheduler: answers IN tokens for NUM_EP endpoints, forwards one
// packet per token and tracks per-endpoint DATA toggle and ZLP obligation.
module bulk_in_sched
  import bulk_in_pkg::*;
#(
  parameter int unsigned NUM_EP  = 2,
  parameter int unsigned EP_BASE = 1,
  parameter int unsigned MAX_PKT = 512
) (
  input  logic                  bulk_ep_in_clock,
  input  logic                  reset_n,
  input  logic                  tok_valid_i,
  input  logic [3:0]            tok_ep_i,
  output logic                  resp_valid_o,
  output logic                  resp_nak_o,
  output logic                  resp_stall_o,
  output logic                  resp_zlp_o,
  output logic                  resp_pid1_o,
  input  logic                  hs_ack_i,
  input  logic                  hs_timeout_i,
  input  logic [NUM_EP-1:0]     toggle_clr_i,
  input  logic [NUM_EP-1:0]     ep_has_data_i,
  output logic [NUM_EP-1:0]     ep_xfer_o,
  input  logic [NUM_EP-1:0]     ep_tvalid_i,
  output logic [NUM_EP-1:0]     ep_tready_o,
  input  logic [NUM_EP-1:0]     ep_tlast_i,
  input  logic [8*NUM_EP-1:0]   ep_tdata_i,
  output logic                  m_tvalid_o,
  input  logic                  m_tready_i,
  output logic                  m_tlast_o,
  output logic [7:0]            m_tdata_o
);

  localparam int unsigned SEL_W = (NUM_EP > 1) ? clog2(NUM_EP) : 1;
  localparam int unsigned CNT_W = clog2(MAX_PKT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_PKT - 1);
  localparam logic [4:0] EP_LO = 5'(EP_BASE);
  localparam logic [4:0] EP_HI = 5'(EP_BASE + NUM_EP);

  state_t               state_q, state_d;
  resp_t                resp_q, resp_d;
  logic                 pid1_q, pid1_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_EP-1:0]    toggle_q, toggle_d;
  logic [NUM_EP-1:0]    zlp_q, zlp_d;
  logic                 is_zlp_q, is_zlp_d;

  logic [4:0]           tok_ext;
  logic                 tok_in_range;
  logic [SEL_W-1:0]     tok_idx;
  logic                 in_xfer;
  logic                 mux_tvalid;
  logic                 src_tlast;
  logic                 cnt_last;
  logic                 beat;

  assign tok_ext      = {1'b0, tok_ep_i};
  assign tok_in_range = (tok_ext >= EP_LO) && (tok_ext < EP_HI);
  assign tok_idx      = SEL_W'(tok_ext - EP_LO);
  assign in_xfer      = (state_q == ST_XFER);

  bulk_in_mux #(
    .NUM_EP (NUM_EP),
    .SEL_W  (SEL_W)
  ) u_mux (
    .en          (in_xfer),
    .sel         (sel_q),
    .ep_tvalid_i (ep_tvalid_i),
    .ep_tlast_i  (ep_tlast_i),
    .ep_tdata_i  (ep_tdata_i),
    .ep_tready_o (ep_tready_o),
    .m_tready_i  (m_tready_i),
    .m_tvalid_o  (mux_tvalid),
    .m_tdata_o   (m_tdata_o),
    .src_tlast_o (src_tlast)
  );

  assign cnt_last   = (cnt_q == CNT_LAST);
  assign m_tvalid_o = mux_tvalid;
  assign m_tlast_o  = in_xfer & (src_tlast | cnt_last);
  assign beat       = mux_tvalid & m_tready_i;

  always_comb begin
    ep_xfer_o = '0;
    if (in_xfer) begin
      for (int unsigned k = 0; k < NUM_EP; k++) begin
        if (sel_q == SEL_W'(k)) ep_xfer_o[k] = 1'b1;
      end
    end
  end

  assign resp_valid_o = (resp_q != RESP_NONE);
  assign resp_nak_o   = (resp_q == RESP_NAK);
  assign resp_stall_o = (resp_q == RESP_STALL);
  assign resp_zlp_o   = (resp_q == RESP_ZLP);
  assign resp_pid1_o  = pid1_q;

  always_ff @(posedge bulk_ep_in_clock) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      resp_q   <= RESP_NONE;
      pid1_q   <= 1'b0;
      sel_q    <= '0;
      cnt_q    <= '0;
      toggle_q <= '0;
      zlp_q    <= '0;
      is_zlp_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      resp_q   <= resp_d;
      pid1_q   <= pid1_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      toggle_q <= toggle_d;
      zlp_q    <= zlp_d;
      is_zlp_q <= is_zlp_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    resp_d   = RESP_NONE;
    pid1_d   = 1'b0;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    toggle_d = toggle_q;
    zlp_d    = zlp_q;
    is_zlp_d = is_zlp_q;
    unique case (state_q)
      ST_IDLE: begin
        if (tok_valid_i) begin
          if (!tok_in_range) begin
            resp_d = RESP_STALL;
          end else if (zlp_q[tok_idx]) begin
            resp_d   = RESP_ZLP;
            pid1_d   = toggle_q[tok_idx];
            sel_d    = tok_idx;
            is_zlp_d = 1'b1;
            state_d  = ST_WAIT_HS;
          end else if (ep_has_data_i[tok_idx]) begin
            resp_d   = RESP_DATA;
            pid1_d   = toggle_q[tok_idx];
            sel_d    = tok_idx;
            cnt_d    = '0;
            is_zlp_d = 1'b0;
            state_d  = ST_XFER;
          end else begin
            resp_d = RESP_NAK;
          end
        end
      end
      ST_XFER: begin
        if (beat) begin
          cnt_d = cnt_q + 1'b1;
          if (m_tlast_o) state_d = ST_WAIT_HS;
          // A full packet that also ends the transfer must be followed by a ZLP.
          if (src_tlast && cnt_last) zlp_d[sel_q] = 1'b1;
        end
      end
      ST_WAIT_HS: begin
        if (hs_ack_i) begin
          toggle_d[sel_q] = ~toggle_q[sel_q];
          if (is_zlp_q) zlp_d[sel_q] = 1'b0;
          state_d = ST_IDLE;
        end else if (hs_timeout_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Configuration-level clear overrides anything decided above this cycle.
    toggle_d = toggle_d & ~toggle_clr_i;
    zlp_d    = zlp_d & ~toggle_clr_i;
  end

endmodule

// File: doc/bulk_in_sched.md
Name: bulk_in_sched

Overview:
- Schedules the shared IN data path of the USB transaction layer across NUM_EP bulk IN endpoints.
- On an IN token it picks the addressed endpoint and either NAKs it or opens that endpoint's transfer window (ep_xfer_o).
- While the window is open it forwards the endpoint's byte stream, cutting a packet at MAX_PKT bytes or at the source tlast.
- Tracks the DATA0/DATA1 toggle and zero-length-packet (ZLP) obligation for each endpoint.

Parameters:
- NUM_EP, 2, number of bulk IN endpoints served (1..8).
- EP_BASE, 1, USB endpoint number of index 0; endpoint k is EP_BASE+k.
- MAX_PKT, 512, max packet size in bytes (8..1024).

Ports:
- bulk_ep_in_clock  in  1  clock
- reset_n  in  1  synchronous active-low reset
- tok_valid_i  in  1  single-cycle IN token strobe from the transaction layer
- tok_ep_i  in  4  endpoint number of the token
- resp_valid_o  out  1  single-cycle response strobe
- resp_nak_o  out  1  response is NAK
- resp_stall_o  out  1  response is STALL (endpoint out of range)
- resp_zlp_o  out  1  response is a zero-length DATA packet
- resp_pid1_o  out  1  data PID: 0=DATA0, 1=DATA1
- hs_ack_i  in  1  host ACK received
- hs_timeout_i  in  1  no handshake before timeout
- toggle_clr_i  in  NUM_EP  per-endpoint toggle reset (SetConfiguration/ClearFeature)
- ep_has_data_i  in  NUM_EP  per-endpoint has-data flags
- ep_xfer_o  out  NUM_EP  one-hot transfer window
- ep_tvalid_i  in  NUM_EP  per-endpoint stream valid
- ep_tready_o  out  NUM_EP  per-endpoint stream ready
- ep_tlast_i  in  NUM_EP  per-endpoint stream last
- ep_tdata_i  in  8*NUM_EP  per-endpoint bytes; index k at [8k+7:8k]
- m_tvalid_o  out  1  packet byte valid
- m_tready_i  in  1  transaction layer ready
- m_tlast_o  out  1  last byte of the packet
- m_tdata_o  out  8  packet byte

Behaviour:
- Reset (reset_n=0 at a clock edge), from any state including mid-packet:
  - state=IDLE.
  - All toggles=0; all zlp_pending=0.
  - ep_xfer_o=0 and all resp_*_o=0.
  - m_tvalid_o=0, m_tlast_o=0, ep_tready_o=0.
- Index decode: idx = tok_ep_i - EP_BASE. The index is valid only when EP_BASE <= tok_ep_i < EP_BASE+NUM_EP. Latched into sel on token acceptance.
- Tokens are accepted only in IDLE; tok_valid_i in any other state is ignored.
- State IDLE, on tok_valid_i, evaluated in this order:
  - Index out of range: resp_valid+resp_stall next cycle; stay in IDLE.
  - zlp_pending[idx]=1: resp_valid+resp_zlp with resp_pid1=toggle[idx] next cycle; go to WAIT_HS.
  - ep_has_data_i[idx]=1: resp_valid with resp_pid1=toggle[idx] next cycle; ep_xfer_o[idx]=1 from the next cycle; byte count cnt=0; go to XFER.
  - Otherwise: resp_valid+resp_nak next cycle; stay in IDLE.
- State XFER:
  - Combinational pass-through, zero latency:
    - m_tvalid_o = ep_tvalid_i[sel]
    - ep_tready_o[sel] = m_tready_i
    - m_tdata_o = selected endpoint's byte
    - m_tlast_o = ep_tlast_i[sel] | (cnt == MAX_PKT-1)
  - Non-selected ep_tready_o bits are 0.
  - cnt increments on each m_tvalid_o & m_tready_i beat.
  - On the last beat (m_tlast_o with handshake): go to WAIT_HS. ep_xfer_o drops the following cycle.
  - If source tlast and the MAX_PKT boundary coincide: set zlp_pending[sel].
  - A MAX_PKT cut without source tlast: the endpoint's stream continues in its next packet. No ZLP is owed.
  - cnt width is clog2(MAX_PKT); it never wraps within a packet.
- State WAIT_HS:
  - hs_ack_i: toggle[sel] flips. If the completed packet was a ZLP, clear zlp_pending[sel]. Go to IDLE.
  - hs_timeout_i: toggle is unchanged. A data packet is not retransmitted (its bytes are already consumed). A ZLP stays pending. Go to IDLE.
  - hs_ack_i and hs_timeout_i together: ACK wins.
- toggle_clr_i[k] forces toggle[k]=0 and zlp_pending[k]=0 in any state. It has priority over an ACK flip in the same cycle.

Decomposition:
- Shared package bulk_in_pkg:
  - state encodings: ST_IDLE, ST_XFER, ST_WAIT_HS
  - function clog2
  - response-code constants
- One natural sub-module: bulk_in_mux (N:1 AXIS select/demux on sel, combinational), instantiated in XFER.
- Toggle and zlp_pending are flop vectors in the top module.

Test Plan:
- Token EP1, ep_has_data=01, source sends 5 bytes 0xA0..0xA4 with tlast on 0xA4, then hs_ack -> response DATA0 without NAK; m_tdata_o carries A0..A4 with m_tlast_o on A4; ep_xfer_o=01 during transfer; toggle[0]=1 afterwards.
- MAX_PKT=8, EP2 streams 8 bytes with tlast on byte 8, ACK; then a second IN token on EP2 -> first packet is 8 bytes with m_tlast_o at cnt=7; second IN returns resp_zlp with DATA1; after ACK, zlp_pending cleared and toggle=0.
- MAX_PKT=8, EP1 streams 12 bytes with tlast on byte 12 -> two packets of 8 and 4 bytes on two consecutive INs, PIDs DATA0 then DATA1; no ZLP.
- Token EP1 with has_data=0 -> resp_nak. Token EP5 with NUM_EP=2 -> resp_stall. State stays IDLE in both cases; ep_xfer_o=0.
- Mid-packet (3 of 6 bytes sent), pulse reset_n=0 -> next cycle m_tvalid_o=0, ep_xfer_o=0, toggles=0. A subsequent token behaves as after reset.
- hs_timeout after a packet, then toggle_clr_i[0] together with hs_ack on a later transfer -> toggle stays 0 after the timeout; clear wins over flip, so toggle[0]=0.
